bcd_mux_display: RTL

Parametrised multiplexed seven-segment display driver for the calculator front panel. Accepts a binary result with a load strobe, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes NUM_DIGITS common-anode digits. Adds leading-zero blanking, overflow indication and tear-free atomic display updates. Sits between the calculator datapath and the board anode/segment pins.

---
 rtl/calc_disp_pkg.sv | 39 +++
 rtl/bin2bcd_seq.sv | 92 +++++++++
 rtl/bcd_mux_display.sv | 101 ++++++++++
 3 files changed

// File: rtl/calc_disp_pkg.sv
// Shared constants, state type and helpers for the calculator display driver.
package calc_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit; anything else is blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle, fixed latency.
module bin2bcd_seq
  import calc_disp_pkg::*;
#(
  parameter int unsigned BIN_W      = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

  conv_state_e       state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, adj_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Add 3 to every nibble that would reach 10 or more after doubling.
  always_comb begin
    adj_c = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (64'(bin_i) >= OVF_LIMIT);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/bcd_mux_display.sv
// Multiplexed common-anode seven-segment driver with blanking, overflow dashes and atomic updates.
module bcd_mux_display
  import calc_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned REFRESH_CNT = 10_000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned RC_W  = $clog2(REFRESH_CNT);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  conv_done, conv_ovf;
  logic [BCD_W-1:0]      conv_bcd;

  logic [RC_W-1:0]       rc_q, rc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BCD_W-1:0]      disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            nib_c;
  logic                  lz_c;

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (load),
    .bin_i   (value),
    .busy_o  (busy),
    .done_o  (conv_done),
    .ovf_o   (conv_ovf),
    .bcd_o   (conv_bcd)
  );

  // Refresh counter and digit index; the display register only moves on a finished conversion.
  always_comb begin
    rc_d   = rc_q + RC_W'(1);
    idx_d  = idx_q;
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (rc_q == RC_W'(REFRESH_CNT - 1)) begin
      rc_d  = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    if (conv_done) begin
      ovf_d = conv_ovf;
      if (!conv_ovf) disp_d = conv_bcd;
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    nib_c = disp_q[{idx_q, 2'b00} +: 4];
    lz_c  = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (i >= 32'(idx_q) && disp_q[4*i +: 4] != 4'd0) lz_c = 1'b0;
    end
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = seg_decode(nib_c);
    if (ovf_q) seg_d = SEG_DASH;
    else if (BLANK_LZ != 0 && idx_q != '0 && lz_c) seg_d = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q   <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      rc_q   <= rc_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign overflow = ovf_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule
